// File: rtl/seq_divider_if.sv
// seq_divider_if: Start/Busy/Done handshake plus operand and result bus of seq_divider.
interface seq_divider_if #(parameter int WIDTH = 32);
    logic             Start;
    logic             Signed;
    logic [WIDTH-1:0] Dividend;
    logic [WIDTH-1:0] Divisor;
    logic             Busy;
    logic             Done;
    logic             DivZero;
    logic [WIDTH-1:0] Quotient;
    logic [WIDTH-1:0] Remainder;
    modport master (output Start, Signed, Dividend, Divisor,
                    input  Busy, Done, DivZero, Quotient, Remainder);
    modport slave  (input  Start, Signed, Dividend, Divisor,
                    output Busy, Done, DivZero, Quotient, Remainder);
endinterface

// File: rtl/seq_divider.sv
// seq_divider: multicycle restoring divider for MIPS DIV/DIVU, one quotient bit per clock.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input logic         Clk,
    input logic         Reset,
    seq_divider_if.slave div_if
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    state_t           state_q;
    logic [WIDTH-1:0] r_q, q_q, d_q, quo_q, rem_q;
    logic [CW-1:0]    cnt_q;
    logic             qneg_q, rneg_q, busy_q, done_q, dz_q;
    logic             a_neg_d, b_neg_d, ge_d;
    logic [WIDTH-1:0] a_abs_d, b_abs_d;
    logic [WIDTH:0]   rs_d, t_d;
    always_comb begin
        a_neg_d = div_if.Signed & div_if.Dividend[WIDTH-1];
        b_neg_d = div_if.Signed & div_if.Divisor[WIDTH-1];
        a_abs_d = a_neg_d ? -div_if.Dividend : div_if.Dividend;
        b_abs_d = b_neg_d ? -div_if.Divisor : div_if.Divisor;
        rs_d    = {r_q, q_q[WIDTH-1]};
        t_d     = rs_d - {1'b0, d_q};
        ge_d    = rs_d >= {1'b0, d_q};
    end
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (div_if.Start) begin
                    if (div_if.Divisor == '0) begin
                        quo_q   <= '1;
                        rem_q   <= div_if.Dividend;
                        dz_q    <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        q_q     <= a_abs_d;
                        d_q     <= b_abs_d;
                        r_q     <= '0;
                        qneg_q  <= a_neg_d ^ b_neg_d;
                        rneg_q  <= a_neg_d;
                        cnt_q   <= CW'(WIDTH - 1);
                        dz_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    // Restoring step: keep the shifted remainder when the trial subtract borrows
                    r_q     <= ge_d ? t_d[WIDTH-1:0] : rs_d[WIDTH-1:0];
                    q_q     <= {q_q[WIDTH-2:0], ge_d};
                    cnt_q   <= cnt_q - 1'b1;
                    state_q <= (cnt_q == '0) ? FIX : CALC;
                end
                FIX: begin
                    quo_q   <= qneg_q ? -q_q : q_q;
                    rem_q   <= rneg_q ? -r_q : r_q;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign div_if.Busy      = busy_q;
    assign div_if.Done      = done_q;
    assign div_if.DivZero   = dz_q;
    assign div_if.Quotient  = quo_q;
    assign div_if.Remainder = rem_q;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and random DIV/DIVU checks of seq_divider against an arithmetic model.
module tb_seq_divider;
    localparam int W = 32;
    logic Clk = 1'b0;
    logic Reset = 1'b1;
    int vectors = 0;
    int miscompares = 0;
    logic [W-1:0] prev_q = '0;
    logic [W-1:0] prev_r = '0;
    seq_divider_if #(.WIDTH(W)) dif ();
    seq_divider #(.WIDTH(W)) dut (.Clk(Clk), .Reset(Reset), .div_if(dif));
    always #5 Clk = ~Clk;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    // Truncating division done in 64-bit arithmetic, so -2^31/-1 needs no special case
    function automatic void model(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
        longint sa, sb, q64, r64;
        dz = (b == 0);
        sa = sg ? longint'($signed(a)) : longint'({32'd0, a});
        sb = sg ? longint'($signed(b)) : longint'({32'd0, b});
        q64 = dz ? -1 : sa / sb;
        r64 = dz ? sa : sa % sb;
        q = q64[W-1:0];
        r = r64[W-1:0];
    endfunction
    task automatic idle_check();
        @(negedge Clk);
        chk("done_pulse", dif.Done, 1'b0);
        chk("idle_busy", dif.Busy, 1'b0);
    endtask
    task automatic do_op(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int inj, input int rst_at);
        logic [W-1:0] eq, er;
        logic edz;
        int n;
        model(sg, a, b, eq, er, edz);
        dif.Signed = sg;
        dif.Dividend = a;
        dif.Divisor = b;
        dif.Start = 1'b1;
        @(negedge Clk);
        dif.Start = 1'b0;
        n = 0;
        while (!dif.Done && n < 100) begin
            chk("busy", dif.Busy, 1'b1);
            chk("hold_q", dif.Quotient, prev_q);
            chk("hold_r", dif.Remainder, prev_r);
            chk("dz_busy", dif.DivZero, 1'b0);
            if (n == rst_at) begin
                Reset = 1'b1;
                #1;
                chk("rst_busy", dif.Busy, 1'b0);
                chk("rst_done", dif.Done, 1'b0);
                chk("rst_dz", dif.DivZero, 1'b0);
                chk("rst_q", dif.Quotient, 0);
                chk("rst_r", dif.Remainder, 0);
                @(negedge Clk);
                Reset = 1'b0;
                prev_q = '0;
                prev_r = '0;
                return;
            end
            dif.Start = (n == inj);
            if (n == inj) begin
                dif.Signed = ~sg;
                dif.Dividend = $urandom;
                dif.Divisor = $urandom;
            end
            @(negedge Clk);
            dif.Start = 1'b0;
            n++;
        end
        chk("latency", n, edz ? 0 : W + 1);
        chk("done_busy", dif.Busy, 1'b0);
        chk("quotient", dif.Quotient, eq);
        chk("remainder", dif.Remainder, er);
        chk("divzero", dif.DivZero, edz);
        prev_q = eq;
        prev_r = er;
    endtask
    initial begin
        logic sg;
        logic [W-1:0] a, b;
        int k;
        dif.Start = 1'b0;
        dif.Signed = 1'b0;
        dif.Dividend = '0;
        dif.Divisor = '0;
        repeat (3) @(negedge Clk);
        chk("reset_busy", dif.Busy, 1'b0);
        chk("reset_done", dif.Done, 1'b0);
        chk("reset_dz", dif.DivZero, 1'b0);
        chk("reset_q", dif.Quotient, 0);
        chk("reset_r", dif.Remainder, 0);
        Reset = 1'b0;
        @(negedge Clk);
        do_op(1'b0, 100, 7, -1, -1);
        chk("t1_q", dif.Quotient, 14);
        chk("t1_r", dif.Remainder, 2);
        idle_check();
        do_op(1'b1, -7, 2, -1, -1);
        chk("t2a_q", dif.Quotient, 32'hFFFF_FFFD);
        chk("t2a_r", dif.Remainder, 32'hFFFF_FFFF);
        idle_check();
        do_op(1'b1, 7, -2, -1, -1);
        chk("t2b_q", dif.Quotient, 32'hFFFF_FFFD);
        chk("t2b_r", dif.Remainder, 1);
        idle_check();
        do_op(1'b0, 5, 0, -1, -1);
        chk("t3_q", dif.Quotient, 32'hFFFF_FFFF);
        chk("t3_r", dif.Remainder, 5);
        chk("t3_dz", dif.DivZero, 1'b1);
        idle_check();
        chk("t3_dz_held", dif.DivZero, 1'b1);
        do_op(1'b1, 9, 3, -1, -1);
        idle_check();
        do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
        chk("t4a_q", dif.Quotient, 32'h8000_0000);
        chk("t4a_r", dif.Remainder, 0);
        idle_check();
        do_op(1'b0, 32'hFFFF_FFFF, 1, -1, -1);
        idle_check();
        do_op(1'b0, 1000, 33, 10, -1);
        dif.Start = 1'b1;
        dif.Signed = 1'b1;
        dif.Dividend = -1000;
        dif.Divisor = 7;
        idle_check();
        do_op(1'b1, -1000, 7, -1, -1);
        idle_check();
        do_op(1'b0, 12345, 67, -1, 15);
        do_op(1'b0, 12345, 67, -1, -1);
        idle_check();
        for (int i = 0; i < 1500; i++) begin
            sg = $urandom_range(0, 1);
            k = $urandom_range(0, 9);
            b = (k == 0) ? 0 : (k == 1) ? (($urandom_range(0, 1) != 0) ? 1 : 32'hFFFF_FFFF)
              : (k < 4) ? $urandom_range(1, 15) : $urandom;
            a = ($urandom_range(0, 15) == 0) ? 32'h8000_0000 : $urandom;
            do_op(sg, a, b, -1, -1);
            idle_check();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
